// File: rtl/sn76489_pkg.sv
// Shared types and byte-encoding helpers for the SN76489 register write path.
package sn76489_pkg;

  typedef enum logic [1:0] {
    TONE1 = 2'd0,
    TONE2 = 2'd1,
    TONE3 = 2'd2,
    NOISE = 2'd3
  } chan_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SETUP  = 3'd2,
    STROBE = 3'd3,
    HOLD   = 3'd4,
    GAP    = 3'd5
  } state_t;

  localparam logic LATCH_BIT = 1'b1;
  localparam int   CMD_W     = 13;

  typedef struct packed {
    chan_t       chan;
    logic        atten;
    logic [9:0]  value;
  } cmd_t;

  function automatic logic [7:0] encode_latch(chan_t chan, logic atten, logic [3:0] nibble);
    return {LATCH_BIT, chan, atten, nibble};
  endfunction

  function automatic logic [7:0] encode_data(logic [5:0] hi);
    return {~LATCH_BIT, 1'b0, hi};
  endfunction

endpackage

// File: rtl/sn76489_bus_writer_if.sv
// Command handshake plus SN76489 write-pin bundle between a command source and the writer.
interface sn76489_bus_writer_if;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [1:0]  cmd_chan_i;
  logic        cmd_atten_i;
  logic [9:0]  cmd_value_i;
  logic        ce_n_o;
  logic        we_n_o;
  logic [7:0]  d_o;
  logic        ready_i;
  logic        busy_o;
  logic        timeout_o;

  modport master (
    output cmd_valid_i, cmd_chan_i, cmd_atten_i, cmd_value_i, ready_i,
    input  cmd_ready_o, ce_n_o, we_n_o, d_o, busy_o, timeout_o
  );

  modport slave (
    input  cmd_valid_i, cmd_chan_i, cmd_atten_i, cmd_value_i, ready_i,
    output cmd_ready_o, ce_n_o, we_n_o, d_o, busy_o, timeout_o
  );
endinterface

// File: rtl/sn_cmd_fifo.sv
// Small synchronous command FIFO; rd_data shows the head entry whenever empty=0.
module sn_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 13
) (
  input  logic             clock_i,
  input  logic             res_i,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clock_i) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clock_i) begin
    if (res_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/sn76489_bus_writer.sv
// Buffers register commands and replays them as SN76489 latch/data byte writes.
//   state  | meaning
//   IDLE   | nothing queued, bus released
//   LOAD   | pop head command, encode byte1 and optional byte2
//   SETUP  | d driven, ce_n low, we_n high
//   STROBE | we_n low until min width met and ready_i seen, or timeout
//   HOLD   | we_n high, ce_n low, d held
//   GAP    | ce_n high between bytes
module sn76489_bus_writer
  import sn76489_pkg::*;
#(
  parameter int DEPTH         = 4,
  parameter int STROBE_CYCLES = 2,
  parameter int GAP_CYCLES    = 1,
  parameter int TIMEOUT       = 64
) (
  input  logic               clock_i,
  input  logic               res_i,
  sn76489_bus_writer_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  state_t          state;
  cmd_t            fifo_wr;
  cmd_t            fifo_rd;
  logic            push;
  logic            pop;
  logic            full;
  logic            empty;
  logic [7:0]      byte2;
  logic            byte2_pend;
  logic [TW-1:0]   tcnt;
  logic [GW-1:0]   gcnt;
  logic            ce_n;
  logic            we_n;
  logic [7:0]      d;
  logic            busy;
  logic            timeout;

  assign push    = bus.cmd_valid_i && !full;
  assign pop     = (state == LOAD);
  assign fifo_wr = '{chan: chan_t'(bus.cmd_chan_i), atten: bus.cmd_atten_i, value: bus.cmd_value_i};

  sn_cmd_fifo #(.DEPTH(DEPTH), .WIDTH(CMD_W)) u_fifo (
    .clock_i (clock_i),
    .res_i   (res_i),
    .push    (push),
    .pop     (pop),
    .wr_data (fifo_wr),
    .rd_data (fifo_rd),
    .full    (full),
    .empty   (empty)
  );

  assign bus.cmd_ready_o = !full;
  assign bus.ce_n_o      = ce_n;
  assign bus.we_n_o      = we_n;
  assign bus.d_o         = d;
  assign bus.busy_o      = busy;
  assign bus.timeout_o   = timeout;

  // tcnt counts down from TIMEOUT-1 on the first STROBE cycle; it equals TIMEOUT minus elapsed cycles.
  always_ff @(posedge clock_i) begin
    if (res_i) begin
      state      <= IDLE;
      ce_n       <= 1'b1;
      we_n       <= 1'b1;
      d          <= 8'h00;
      busy       <= 1'b0;
      timeout    <= 1'b0;
      byte2      <= 8'h00;
      byte2_pend <= 1'b0;
      tcnt       <= '0;
      gcnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Looking at push as well as empty saves a cycle of first-command latency.
          if (!empty || push) begin
            state <= LOAD;
            busy  <= 1'b1;
          end else begin
            busy  <= 1'b0;
          end
        end
        LOAD: begin
          state <= SETUP;
          ce_n  <= 1'b0;
          we_n  <= 1'b1;
          if (fifo_rd.atten) begin
            d          <= encode_latch(fifo_rd.chan, 1'b1, fifo_rd.value[3:0]);
            byte2_pend <= 1'b0;
          end else if (fifo_rd.chan == NOISE) begin
            d          <= encode_latch(NOISE, 1'b0, {1'b0, fifo_rd.value[2:0]});
            byte2_pend <= 1'b0;
          end else begin
            d          <= encode_latch(fifo_rd.chan, 1'b0, fifo_rd.value[3:0]);
            byte2      <= encode_data(fifo_rd.value[9:4]);
            byte2_pend <= 1'b1;
          end
        end
        SETUP: begin
          state <= STROBE;
          we_n  <= 1'b0;
          tcnt  <= TW'(TIMEOUT - 1);
        end
        STROBE: begin
          if (bus.ready_i && (tcnt <= TW'(TIMEOUT - STROBE_CYCLES))) begin
            state <= HOLD;
            we_n  <= 1'b1;
          end else if (tcnt == '0) begin
            state   <= HOLD;
            we_n    <= 1'b1;
            timeout <= 1'b1;
          end else begin
            tcnt <= tcnt - TW'(1);
          end
        end
        HOLD: begin
          state <= GAP;
          ce_n  <= 1'b1;
          gcnt  <= GW'(GAP_CYCLES - 1);
        end
        GAP: begin
          if (gcnt != '0) begin
            gcnt <= gcnt - GW'(1);
          end else if (byte2_pend) begin
            state      <= SETUP;
            ce_n       <= 1'b0;
            d          <= byte2;
            byte2_pend <= 1'b0;
          end else if (!empty) begin
            state <= LOAD;
          end else begin
            state <= IDLE;
            busy  <= push;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sn76489_bus_writer.sv
// Self-checking bench: vector table, directed corner sequences and a randomized run against a byte-level model.
module tb_sn76489_bus_writer;
  localparam int DEPTH         = 4;
  localparam int STROBE_CYCLES = 2;
  localparam int GAP_CYCLES    = 1;
  localparam int TIMEOUT       = 64;
  localparam int BYTE_CE_LOW   = 1 + STROBE_CYCLES + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sn76489_bus_writer_if bus();

  sn76489_bus_writer #(
    .DEPTH(DEPTH), .STROBE_CYCLES(STROBE_CYCLES), .GAP_CYCLES(GAP_CYCLES), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock_i (clk),
    .res_i   (rst),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int         len_q[$];
  int         gap_q[$];
  int         ce_low;
  int         ce_high;
  logic       prev_we;
  logic       prev_ce;
  logic [7:0] d_first;
  logic       d_bad;

  typedef struct {
    logic [1:0] ch;
    logic       at;
    logic [9:0] v;
    logic [7:0] b1;
    logic [7:0] b2;
    bit         two;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Bus monitor: captures each byte at the we_n rising edge and measures ce_n low/high runs.
  always @(negedge clk) begin
    if (rst) begin
      prev_we = 1'b1;
      prev_ce = 1'b1;
      ce_low  = 0;
      ce_high = 0;
      d_bad   = 1'b0;
    end else begin
      if (prev_ce && !bus.ce_n_o) begin
        gap_q.push_back(ce_high);
        ce_low  = 0;
        d_first = bus.d_o;
        d_bad   = 1'b0;
      end
      if (!prev_ce && bus.ce_n_o) begin
        len_q.push_back(ce_low);
        check("d_stable", d_bad, 1'b0);
        ce_high = 0;
      end
      if (!bus.ce_n_o) begin
        ce_low++;
        if (bus.d_o !== d_first) d_bad = 1'b1;
      end else begin
        ce_high++;
      end
      if (!prev_we && bus.we_n_o && !bus.ce_n_o) got_q.push_back(bus.d_o);
      prev_we = bus.we_n_o;
      prev_ce = bus.ce_n_o;
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_mon();
    got_q.delete();
    exp_q.delete();
    len_q.delete();
    gap_q.delete();
  endtask

  // Reference encoding straight from the register byte formats.
  task automatic expect_cmd(input logic [1:0] ch, input logic at, input logic [9:0] v);
    int c;
    int val;
    c   = int'(ch);
    val = int'(v);
    if (at)          exp_q.push_back(8'(128 + c * 32 + 16 + val % 16));
    else if (c == 3) exp_q.push_back(8'(128 + 96 + val % 8));
    else begin
      exp_q.push_back(8'(128 + c * 32 + val % 16));
      exp_q.push_back(8'(val / 16));
    end
  endtask

  task automatic send(input logic [1:0] ch, input logic at, input logic [9:0] v);
    int n;
    bus.cmd_chan_i  = ch;
    bus.cmd_atten_i = at;
    bus.cmd_value_i = v;
    bus.cmd_valid_i = 1'b1;
    n = 0;
    while (!bus.cmd_ready_o && n < 1000) begin
      cyc();
      n++;
    end
    if (!bus.cmd_ready_o) begin
      checks++;
      errors++;
      $display("FAIL send: cmd_ready_o stayed 0 for %0d cycles", n);
    end
    cyc();
    bus.cmd_valid_i = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output int n);
    n = 0;
    while (bus.busy_o && n < budget) begin
      cyc();
      n++;
    end
    if (bus.busy_o) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: busy_o still 1 after %0d cycles", budget);
    end
  endtask

  task automatic wait_we_low(input int budget);
    int n;
    n = 0;
    while (bus.we_n_o && n < budget) begin
      cyc();
      n++;
    end
    if (bus.we_n_o) begin
      checks++;
      errors++;
      $display("FAIL wait_we_low: we_n_o still 1 after %0d cycles", budget);
    end
  endtask

  task automatic compare_bytes(input string tag);
    int i;
    i = 0;
    while (exp_q.size() > 0) begin
      if (got_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s_missing: got no byte expected 0x%0h at index %0d", tag, exp_q[0], i);
        void'(exp_q.pop_front());
      end else begin
        check($sformatf("%s_byte%0d", tag, i), got_q.pop_front(), exp_q.pop_front());
      end
      i++;
    end
    check({tag, "_extra_bytes"}, got_q.size(), 0);
  endtask

  vec_t vecs[9];

  initial begin
    int n;
    int cnt;
    logic [1:0] rch;
    logic       rat;
    logic [9:0] rv;

    vecs[0] = '{2'd0, 1'b0, 10'h3A5, 8'h85, 8'h3A, 1'b1};
    vecs[1] = '{2'd2, 1'b1, 10'h00F, 8'hDF, 8'h00, 1'b0};
    vecs[2] = '{2'd3, 1'b0, 10'h3FD, 8'hE5, 8'h00, 1'b0};
    vecs[3] = '{2'd1, 1'b0, 10'h07F, 8'hAF, 8'h07, 1'b1};
    vecs[4] = '{2'd3, 1'b1, 10'h2A3, 8'hF3, 8'h00, 1'b0};
    vecs[5] = '{2'd2, 1'b0, 10'h000, 8'hC0, 8'h00, 1'b1};
    vecs[6] = '{2'd0, 1'b1, 10'h3F0, 8'h90, 8'h00, 1'b0};
    vecs[7] = '{2'd3, 1'b0, 10'h004, 8'hE4, 8'h00, 1'b0};
    vecs[8] = '{2'd2, 1'b0, 10'h3FF, 8'hCF, 8'h3F, 1'b1};

    bus.cmd_valid_i = 1'b0;
    bus.cmd_chan_i  = 2'd0;
    bus.cmd_atten_i = 1'b0;
    bus.cmd_value_i = 10'h000;
    bus.ready_i     = 1'b1;

    // Reset values
    cyc(3);
    check("rst_cmd_ready", bus.cmd_ready_o, 1'b1);
    check("rst_ce_n", bus.ce_n_o, 1'b1);
    check("rst_we_n", bus.we_n_o, 1'b1);
    check("rst_d", bus.d_o, 8'h00);
    check("rst_busy", bus.busy_o, 1'b0);
    check("rst_timeout", bus.timeout_o, 1'b0);
    rst = 1'b0;
    cyc(2);

    // First-command latency
    clear_mon();
    bus.cmd_chan_i  = 2'd0;
    bus.cmd_atten_i = 1'b1;
    bus.cmd_value_i = 10'h005;
    bus.cmd_valid_i = 1'b1;
    cyc();
    bus.cmd_valid_i = 1'b0;
    check("lat_c1_busy", bus.busy_o, 1'b1);
    check("lat_c1_ce_n", bus.ce_n_o, 1'b1);
    cyc();
    check("lat_c2_ce_n", bus.ce_n_o, 1'b0);
    check("lat_c2_we_n", bus.we_n_o, 1'b1);
    check("lat_c2_d", bus.d_o, 8'h95);
    cyc();
    check("lat_c3_we_n", bus.we_n_o, 1'b0);
    wait_idle(100, n);
    exp_q.push_back(8'h95);
    compare_bytes("lat");
    check("lat_ce_len", (len_q.size() > 0) ? len_q[0] : -1, BYTE_CE_LOW);

    // Table-driven single commands with ready_i held high
    for (int i = 0; i < 9; i++) begin
      clear_mon();
      send(vecs[i].ch, vecs[i].at, vecs[i].v);
      wait_idle(200, n);
      check($sformatf("vec%0d_busy_cycles", i), n,
            1 + (vecs[i].two ? 2 : 1) * (2 + STROBE_CYCLES + GAP_CYCLES));
      check($sformatf("vec%0d_nbytes", i), got_q.size(), vecs[i].two ? 2 : 1);
      check($sformatf("vec%0d_b1", i), (got_q.size() > 0) ? got_q[0] : 8'hxx, vecs[i].b1);
      check($sformatf("vec%0d_ce_len1", i), (len_q.size() > 0) ? len_q[0] : -1, BYTE_CE_LOW);
      if (vecs[i].two) begin
        check($sformatf("vec%0d_b2", i), (got_q.size() > 1) ? got_q[1] : 8'hxx, vecs[i].b2);
        check($sformatf("vec%0d_ce_len2", i), (len_q.size() > 1) ? len_q[1] : -1, BYTE_CE_LOW);
        check($sformatf("vec%0d_gap", i), (gap_q.size() > 1) ? gap_q[1] : -1, GAP_CYCLES);
      end
      cyc(2);
    end

    // ready_i low for 20 STROBE cycles
    clear_mon();
    bus.ready_i = 1'b0;
    send(2'd1, 1'b1, 10'h003);
    wait_we_low(20);
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (!bus.we_n_o) cnt++;
      cyc();
    end
    check("stall_we_low_cycles", cnt, 20);
    bus.ready_i = 1'b1;
    cyc();
    check("stall_hold_we_n", bus.we_n_o, 1'b1);
    check("stall_hold_ce_n", bus.ce_n_o, 1'b0);
    wait_idle(100, n);
    check("stall_timeout", bus.timeout_o, 1'b0);
    exp_q.push_back(8'hB3);
    compare_bytes("stall");

    // ready_i stuck low: both tone bytes time out and are still sent
    clear_mon();
    bus.ready_i = 1'b0;
    send(2'd1, 1'b0, 10'h123);
    wait_we_low(20);
    cnt = 0;
    while (!bus.we_n_o && cnt < 200) begin
      cnt++;
      cyc();
    end
    check("to_strobe_len", cnt, TIMEOUT);
    check("to_flag", bus.timeout_o, 1'b1);
    check("to_hold_ce_n", bus.ce_n_o, 1'b0);
    wait_idle(500, n);
    check("to_released_ce_n", bus.ce_n_o, 1'b1);
    exp_q.push_back(8'hA3);
    exp_q.push_back(8'h12);
    compare_bytes("to");
    bus.ready_i = 1'b1;
    send(2'd0, 1'b1, 10'h001);
    wait_idle(100, n);
    exp_q.push_back(8'h91);
    compare_bytes("to_next");
    check("to_sticky", bus.timeout_o, 1'b1);

    // Back-pressure: FSM stalled on a first command, then five commands queued
    clear_mon();
    bus.ready_i = 1'b0;
    send(2'd3, 1'b1, 10'h000);
    expect_cmd(2'd3, 1'b1, 10'h000);
    wait_we_low(20);
    for (int i = 0; i < 5; i++) begin
      case (i)
        0:       begin rch = 2'd0; rat = 1'b0; rv = 10'h155; end
        1:       begin rch = 2'd1; rat = 1'b1; rv = 10'h00A; end
        2:       begin rch = 2'd3; rat = 1'b0; rv = 10'h006; end
        3:       begin rch = 2'd2; rat = 1'b0; rv = 10'h2C4; end
        default: begin rch = 2'd0; rat = 1'b1; rv = 10'h00F; end
      endcase
      bus.cmd_chan_i  = rch;
      bus.cmd_atten_i = rat;
      bus.cmd_value_i = rv;
      bus.cmd_valid_i = 1'b1;
      n = 0;
      while (!bus.cmd_ready_o && n < 300) begin
        cyc();
        n++;
      end
      if (!bus.cmd_ready_o) begin
        checks++;
        errors++;
        $display("FAIL bp_accept%0d: cmd_ready_o stayed 0", i);
      end
      expect_cmd(rch, rat, rv);
      cyc();
      if (i == 2) check("bp_ready_after_3", bus.cmd_ready_o, 1'b1);
      if (i == 3) begin
        check("bp_ready_after_4", bus.cmd_ready_o, 1'b0);
        bus.ready_i = 1'b1;
      end
    end
    bus.cmd_valid_i = 1'b0;
    wait_idle(1000, n);
    compare_bytes("bp");

    // Reset pulsed mid-strobe abandons the write and flushes the queue
    clear_mon();
    bus.ready_i = 1'b0;
    send(2'd0, 1'b0, 10'h3A5);
    send(2'd2, 1'b1, 10'h005);
    wait_we_low(20);
    rst = 1'b1;
    cyc();
    check("rr_ce_n", bus.ce_n_o, 1'b1);
    check("rr_we_n", bus.we_n_o, 1'b1);
    check("rr_busy", bus.busy_o, 1'b0);
    check("rr_cmd_ready", bus.cmd_ready_o, 1'b1);
    check("rr_timeout", bus.timeout_o, 1'b0);
    rst = 1'b0;
    got_q.delete();
    bus.ready_i = 1'b1;
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      cyc();
      if (bus.busy_o || !bus.ce_n_o) cnt++;
    end
    check("rr_no_retry_activity", cnt, 0);
    check("rr_no_bytes", got_q.size(), 0);

    // Randomized commands and ready_i against the byte model
    clear_mon();
    cnt = 0;
    n   = 0;
    while (cnt < 150 && n < 20000) begin
      bus.ready_i = ($urandom_range(3) != 0);
      if ($urandom_range(1) == 1) begin
        rch = 2'($urandom_range(3));
        rat = 1'($urandom_range(1));
        rv  = 10'($urandom_range(1023));
        bus.cmd_chan_i  = rch;
        bus.cmd_atten_i = rat;
        bus.cmd_value_i = rv;
        bus.cmd_valid_i = 1'b1;
        if (bus.cmd_ready_o) begin
          expect_cmd(rch, rat, rv);
          cnt++;
        end
      end else begin
        bus.cmd_valid_i = 1'b0;
      end
      cyc();
      n++;
    end
    bus.cmd_valid_i = 1'b0;
    bus.ready_i     = 1'b1;
    check("rnd_sent", cnt, 150);
    wait_idle(3000, n);
    compare_bytes("rnd");
    check("rnd_timeout", bus.timeout_o, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
